// File: rtl/ysyx_23060240_ifu_fsm.sv
// Instruction fetch unit: fetches one instruction at a time from a
// registered-read instruction SRAM. It presents the instruction to decode
// with a valid/ready handshake, then waits for write-back to supply the
// next PC before it starts the next fetch.
module ysyx_23060240_ifu_fsm #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_r_en,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [31:0] inst_cnt,
  output logic        npc_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_VALID,
    S_WAIT_NPC
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_cnt;
  logic        r_misalign;

  logic        w_handshake;
  logic        w_npc_take;
  logic        w_capture;

  // Only WAIT_NPC listens to the write-back stage; npc_valid is ignored elsewhere.
  assign w_handshake = (r_state == S_VALID) && out_ready;
  assign w_npc_take  = (r_state == S_WAIT_NPC) && npc_valid;
  assign w_capture   = (r_state == S_RESP);

  // State register; reset drops back to IDLE at once, discarding any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: one fetch is in flight at a time, REQ -> RESP -> VALID.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     w_state_next = S_REQ;
      S_REQ:      w_state_next = S_RESP;
      S_RESP:     w_state_next = S_VALID;
      S_VALID:    if (out_ready) w_state_next = S_WAIT_NPC;
      S_WAIT_NPC: if (npc_valid) w_state_next = S_REQ;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers: PC, captured instruction, handshake counter, sticky misalign flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_inst_cnt <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_npc_take) begin
        r_pc <= npc;
      end
      if (w_npc_take && (npc[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
      if (w_capture) begin
        r_inst <= mem_rdata;
      end
      if (w_handshake) begin
        r_inst_cnt <= r_inst_cnt + 32'd1;
      end
    end
  end

  // Outputs are decoded from the state alone, so they follow reset immediately.
  always_comb begin
    mem_r_en     = (r_state == S_REQ);
    mem_raddr    = r_pc;
    out_valid    = (r_state == S_VALID);
    out_pc       = r_pc;
    out_inst     = r_inst;
    inst_cnt     = r_inst_cnt;
    npc_misalign = r_misalign;
  end

endmodule

// File: tb/tb_ysyx_23060240_ifu_fsm.sv
// Bench for the fetch unit: SRAM model with contents derived from the
// address, a scoreboard queue of expected (pc, inst) responses fed by the
// stimulus, and a negedge monitor that checks the DUT outputs against it.
module tb_ysyx_23060240_ifu_fsm;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] inst_cnt;
  logic        npc_misalign;

  ysyx_23060240_ifu_fsm #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .npc_valid(npc_valid), .npc(npc),
    .inst_cnt(inst_cnt), .npc_misalign(npc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Registered-read SRAM: data valid the cycle after the read enable
  always @(posedge clk) begin
    if (mem_r_en) mem_rdata <= mem_word(mem_raddr);
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  bit          m_busy;
  bit          m_shown;
  int          m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    q.delete();
    m_pc    = RESET_PC;
    m_cnt   = 32'h0;
    m_mis   = 1'b0;
    m_busy  = 1'b0;
    m_shown = 1'b0;
    m_lat   = 0;
    e.pc    = RESET_PC;
    e.inst  = mem_word(RESET_PC);
    q.push_back(e);
  endtask

  // Monitor: checks every cycle against the reference, pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_raddr", mem_raddr, m_pc);
      chk("inst_cnt", inst_cnt, m_cnt);
      chk("npc_misalign", {31'h0, npc_misalign}, {31'h0, m_mis});
      if (mem_r_en) begin
        chk("single_fetch", {31'h0, m_busy}, 32'h0);
        chk("fetch_pending", q.size(), 1);
        chk("en_vs_valid", {31'h0, out_valid}, 32'h0);
        m_busy = 1'b1;
        m_lat  = 0;
      end else if (m_busy && !m_shown) begin
        m_lat++;
      end
      if (out_valid) begin
        if (!m_shown) chk("fetch_latency", m_lat, 2);
        m_shown = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'h1, 32'h0);
        end else begin
          chk("out_pc", out_pc, q[0].pc);
          chk("out_inst", out_inst, q[0].inst);
          if (out_ready) begin
            $display("handshake pc=%h inst=%h cnt=%h", out_pc, out_inst, m_cnt + 32'd1);
            void'(q.pop_front());
            m_cnt   = m_cnt + 32'd1;
            m_busy  = 1'b0;
            m_shown = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_valid();
    int budget = 20;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!out_valid) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  // One full fetch: stall in VALID, handshake, gap, then supply next PC
  task automatic do_fetch(input int stall, input int gap, input bit stray,
                          input bit wrap, input logic [31:0] next);
    exp_t e;
    wait_valid();
    if (wrap) begin
      force dut.r_inst_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_inst_cnt;
      m_cnt = 32'hFFFF_FFFF;
    end
    for (int k = 0; k < stall; k++) begin
      if (stray && k == 0) begin
        npc_valid = 1'b1;
        npc = $urandom;
      end
      @(posedge clk); #1;
      npc_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
    end
    e.pc   = next;
    e.inst = mem_word(next);
    q.push_back(e);
    npc_valid = 1'b1;
    npc = next;
    @(posedge clk); #1;
    npc_valid = 1'b0;
    npc = 32'h0;
    m_pc = next;
    if (next[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  // First fetch timing right after reset release
  task automatic check_restart();
    @(posedge clk); #1;
    chk("rst_rel_r_en", {31'h0, mem_r_en}, 32'h1);
    chk("rst_rel_addr", mem_raddr, RESET_PC);
    @(posedge clk); #1;
    chk("resp_r_en", {31'h0, mem_r_en}, 32'h0);
    chk("resp_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("first_valid", {31'h0, out_valid}, 32'h1);
    chk("first_inst", out_inst, 32'h0000_0413);
    chk("first_pc", out_pc, RESET_PC);
  endtask

  task automatic check_reset_values();
    chk("rst_r_en", {31'h0, mem_r_en}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_addr", mem_raddr, RESET_PC);
    chk("rst_cnt", inst_cnt, 32'h0);
    chk("rst_mis", {31'h0, npc_misalign}, 32'h0);
  endtask

  initial begin
    logic [31:0] nxt;
    int          stall;
    int          gap;
    bit          stray;
    rst = 1'b1;
    out_ready = 1'b0;
    npc_valid = 1'b0;
    npc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    check_restart();

    // Long stall with a stray npc pulse, then jump to 8000_0010
    do_fetch(5, 1, 1'b1, 1'b0, 32'h8000_0010);
    chk("npc_r_en", {31'h0, mem_r_en}, 32'h1);
    chk("npc_addr", mem_raddr, 32'h8000_0010);
    chk("cnt_after_first", inst_cnt, 32'h1);
    do_fetch(2, 0, 1'b1, 1'b0, 32'h8000_0006);
    chk("mis_set", {31'h0, npc_misalign}, 32'h1);
    chk("mis_pc", mem_raddr, 32'h8000_0006);
    do_fetch(0, 2, 1'b0, 1'b0, 32'h8000_0020);
    do_fetch(1, 0, 1'b0, 1'b0, 32'h8000_0024);
    chk("mis_held", {31'h0, npc_misalign}, 32'h1);

    // Reset asserted while in RESP
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_r_en", {31'h0, mem_r_en}, 32'h0);
    chk("rst_hold_valid", {31'h0, out_valid}, 32'h0);
    rst = 1'b0;
    check_restart();

    // Counter wrap via backdoor preset
    do_fetch(2, 1, 1'b0, 1'b1, 32'h8000_0040);
    chk("cnt_wrap", inst_cnt, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      stall = $urandom_range(0, 4);
      gap   = $urandom_range(0, 3);
      stray = ($urandom_range(0, 3) == 0) && (stall > 0);
      nxt   = RESET_PC + ({24'h0, 8'($urandom_range(0, 255))} << 2);
      if ($urandom_range(0, 7) == 0) nxt = nxt + 32'($urandom_range(1, 3));
      do_fetch(stall, gap, stray, 1'b0, nxt);
    end
    wait_valid();
    repeat (2) @(negedge clk);
    chk("final_pending", q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060240_ifu_fsm.md
YSYX_23060240_IFU_FSM -- requirements
Module: ysyx_23060240_ifu_fsm

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_r_en  output  1  read enable to instruction SRAM.
REQ-005 mem_raddr  output  32  fetch address to instruction SRAM.
REQ-006 mem_rdata  input  32  SRAM read data, registered; valid exactly one cycle after mem_r_en=1.
REQ-007 out_valid  output  1  instruction available to decode stage.
REQ-008 out_ready  input  1  decode stage accepts instruction.
REQ-009 out_pc  output  32  PC of presented instruction.
REQ-010 out_inst  output  32  presented instruction word.
REQ-011 npc_valid  input  1  write-back stage supplies next PC.
REQ-012 npc  input  32  next PC value.
REQ-013 inst_cnt  output  32  count of instructions handed to decode.
REQ-014 npc_misalign  output  1  sticky flag: npc accepted with npc[1:0]!=0.

Function
REQ-015 FSM states SHALL be IDLE, REQ, RESP, VALID, WAIT_NPC; exactly one active per cycle.
REQ-016 IDLE -> REQ unconditionally on the first clk edge after rst deasserts.
REQ-017 REQ: mem_r_en=1, mem_raddr=pc; -> RESP next edge.
REQ-018 RESP: mem_r_en=0; inst_reg SHALL capture mem_rdata on the edge leaving RESP; -> VALID.
REQ-019 VALID: out_valid=1, out_inst=inst_reg, out_pc=pc; stays in VALID while out_ready=0 with out_inst/out_pc held stable.
REQ-020 VALID with out_ready=1 SHALL complete handshake: -> WAIT_NPC, inst_cnt += 1 (mod 2^32, wraps to 0).
REQ-021 WAIT_NPC: out_valid=0; on npc_valid=1, pc <= npc, -> REQ; otherwise hold.
REQ-022 npc_valid in any state other than WAIT_NPC SHALL be ignored (pc unchanged).
REQ-023 npc accepted with npc[1:0]!=0 SHALL still load pc unmodified and set npc_misalign=1 until reset.
REQ-024 mem_r_en SHALL be 0 in every state except REQ; mem_raddr SHALL equal pc in all states.
REQ-025 out_valid SHALL be 0 in every state except VALID.
REQ-026 Fetch latency: from entry into REQ to out_valid=1 SHALL be exactly 2 cycles.
REQ-027 Single fetch in flight: no new mem_r_en until the previous instruction handshaken and npc received.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, inst_reg=0, inst_cnt=0, npc_misalign=0, mem_r_en=0, out_valid=0, immediately (asynchronous).
REQ-029 rst asserted mid-operation (any state) SHALL abort the fetch; pending SRAM data on the following cycle SHALL be discarded; restart per REQ-016.

Verification
REQ-030 Reset release, SRAM[8000_0000]=0x00000413 -> mem_r_en=1 addr 8000_0000 cycle 1; out_valid=1, out_inst=0x00000413, out_pc=8000_0000 cycle 3.
REQ-031 out_ready=0 for 5 cycles in VALID -> out_valid/out_inst/out_pc stable 5 cycles, inst_cnt unchanged; out_ready=1 -> inst_cnt=1.
REQ-032 WAIT_NPC, npc_valid=1 npc=8000_0010 -> next cycle mem_r_en=1 mem_raddr=8000_0010; npc_valid pulsed during VALID -> no pc change.
REQ-033 npc=8000_0006 -> pc=8000_0006, npc_misalign=1 held through subsequent fetches until rst.
REQ-034 rst pulsed during RESP -> mem_r_en=0, out_valid=0, pc=8000_0000; first fetch after release reads 8000_0000 again.
REQ-035 inst_cnt forced near wrap (run 2^32 handshakes or backdoor 32'hFFFF_FFFF) + one handshake -> inst_cnt=0.
